// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, 32 steps per operation.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] ResultE
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;
  logic [32:0] prem;
  logic [31:0] quot;

  // Request decode: signedness, magnitudes and special cases
  logic        is_div;
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_res;
  logic        accept;

  assign is_div      = Funct3E[2];
  assign a_signed_in = !(Funct3E == OP_MULHU || Funct3E == OP_DIVU || Funct3E == 3'b111);
  assign b_signed_in = a_signed_in && (Funct3E != OP_MULHSU);
  assign a_neg_in    = a_signed_in && RD1E[31];
  assign b_neg_in    = b_signed_in && RD2E[31];
  assign a_mag_in    = a_neg_in ? (32'd0 - RD1E) : RD1E;
  assign b_mag_in    = b_neg_in ? (32'd0 - RD2E) : RD2E;
  assign div_zero    = is_div && (RD2E == 32'd0);
  assign div_ovf     = is_div && !Funct3E[0] &&
                       (RD1E == 32'h8000_0000) && (RD2E == 32'hFFFF_FFFF);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (Funct3E[1] ? RD1E : 32'hFFFF_FFFF)
                                : (Funct3E[1] ? 32'd0 : 32'h8000_0000);
  assign accept      = StartE && !FlushE && (state != CALC);

  assign BusyE = (state == CALC) || (accept && !special);

  // One iteration step of both datapaths, plus the sign-corrected result
  logic [32:0] mul_sum;
  logic [63:0] acc_nxt;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [32:0] prem_nxt;
  logic [31:0] quot_nxt;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] calc_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    acc_nxt   = {mul_sum, acc[31:1]};
    div_shift = {prem[31:0], quot[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
    prem_nxt  = div_shift;
    quot_nxt  = {quot[30:0], 1'b0};
    if (!div_diff[33]) begin
      prem_nxt = div_diff[32:0];
      quot_nxt = {quot[30:0], 1'b1};
    end
    prod_s = (a_neg ^ b_neg) ? (64'd0 - acc_nxt) : acc_nxt;
    quot_s = (a_neg ^ b_neg) ? (32'd0 - quot_nxt) : quot_nxt;
    rem_s  = a_neg ? (32'd0 - prem_nxt[31:0]) : prem_nxt[31:0];
    calc_res = rem_s;
    case (op)
      OP_MUL:                      calc_res = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_s[63:32];
      OP_DIV, OP_DIVU:             calc_res = quot_s;
      default:                     calc_res = rem_s;
    endcase
  end

  // The remainder never reaches 2^32, so its top bit only guards the subtract.
  logic unused_ok;
  assign unused_ok = ^{prem[32], prem_nxt[32]};

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // operand and accumulator alike, is cleared by reset so no stale operation survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      op      <= 3'd0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      a_mag   <= 32'd0;
      b_mag   <= 32'd0;
      acc     <= 64'd0;
      prem    <= 33'd0;
      quot    <= 32'd0;
      DoneE   <= 1'b0;
      ResultE <= 32'd0;
    end else begin
      DoneE <= 1'b0;
      case (state)
        CALC: begin
          if (FlushE) begin
            state <= IDLE;
            cnt   <= 5'd0;
          end else begin
            acc  <= acc_nxt;
            prem <= prem_nxt;
            quot <= quot_nxt;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state   <= DONE;
              DoneE   <= 1'b1;
              ResultE <= calc_res;
            end
          end
        end
        default: begin
          if (accept) begin
            op    <= Funct3E;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            acc   <= {32'd0, b_mag_in};
            prem  <= 33'd0;
            quot  <= a_mag_in;
            cnt   <= 5'd0;
            if (special) begin
              state   <= DONE;
              DoneE   <= 1'b1;
              ResultE <= special_res;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
